// File: rtl/color_palette_regs.sv
// Double-buffered 32 x 8 colour palette: host reads/writes a shadow bank, pixels are looked up
// from an active bank that is refreshed from the shadow only at frame start.
module color_palette_regs #(
   parameter int                    ADDR_WIDTH    = 5,
   parameter int                    DATA_WIDTH    = 8,
   parameter logic [DATA_WIDTH-1:0] C_RESET_COLOR = '0
) (
   input  logic                  i_Clk,
   input  logic                  i_Reset,
   input  logic                  i_write_en,
   input  logic [ADDR_WIDTH-1:0] i_write_addr,
   input  logic [DATA_WIDTH-1:0] i_write_data,
   input  logic                  i_read_en,
   input  logic [ADDR_WIDTH-1:0] i_read_addr,
   output logic [DATA_WIDTH-1:0] o_read_data,
   output logic                  o_read_valid,
   input  logic                  i_Frame_Start,
   input  logic                  i_Commit_Hold,
   input  logic [ADDR_WIDTH-1:0] i_Pixel_Index,
   output logic [DATA_WIDTH-1:0] o_Pixel_Color,
   output logic                  o_Dirty,
   output logic                  o_Commit
);

   localparam int NUM_ENTRIES = 2 ** ADDR_WIDTH;

   typedef enum logic {
      ST_CLEAN = 1'b0,
      ST_DIRTY = 1'b1
   } state_t;

   logic [DATA_WIDTH-1:0] shadow [NUM_ENTRIES];
   logic [DATA_WIDTH-1:0] active [NUM_ENTRIES];

   state_t                state_q, state_d;
   logic                  commit_go;
   logic                  commit_q;
   logic [ADDR_WIDTH-1:0] pix_idx_q;
   logic [DATA_WIDTH-1:0] pix_color_q;
   logic [DATA_WIDTH-1:0] read_data_q;
   logic                  read_valid_q;

   // Commit FSM next-state logic.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      commit_go = 1'b0;
      unique case (state_q)
         ST_CLEAN: begin
            if (i_write_en) state_d = ST_DIRTY;
         end
         ST_DIRTY: begin
            if (i_Frame_Start && !i_Commit_Hold) begin
               commit_go = 1'b1;
               // A write landing on the commit cycle is not part of the copy.
               state_d   = i_write_en ? ST_DIRTY : ST_CLEAN;
            end
         end
         default: state_d = ST_CLEAN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so the commit copies pre-write shadow
   // and the pixel stage samples pre-commit active contents on the same edge.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q      <= ST_CLEAN;
         commit_q     <= 1'b0;
         pix_idx_q    <= '0;
         pix_color_q  <= '0;
         read_data_q  <= '0;
         read_valid_q <= 1'b0;
         // NOTE: both banks are flop arrays with a defined reset colour, so they are reset here;
         // a RAM-mapped memory would normally be left unreset.
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            shadow[i] <= C_RESET_COLOR;
            active[i] <= C_RESET_COLOR;
         end
      end else begin
         state_q      <= state_d;
         commit_q     <= commit_go;
         pix_idx_q    <= i_Pixel_Index;
         pix_color_q  <= active[pix_idx_q];
         read_valid_q <= i_read_en;
         if (i_read_en) read_data_q <= shadow[i_read_addr];
         if (i_write_en) shadow[i_write_addr] <= i_write_data;
         if (commit_go) begin
            for (int i = 0; i < NUM_ENTRIES; i++) active[i] <= shadow[i];
         end
      end
   end

   assign o_read_data   = read_data_q;
   assign o_read_valid  = read_valid_q;
   assign o_Pixel_Color = pix_color_q;
   assign o_Dirty       = (state_q == ST_DIRTY);
   assign o_Commit      = commit_q;

endmodule

// File: tb/tb_color_palette_regs.sv
// Self-checking bench for color_palette_regs: host reads are scoreboarded through a queue,
// pixel/commit/dirty behaviour is checked against constants at fixed cycle offsets.
module tb_color_palette_regs;

   logic       i_Clk = 1'b0;
   logic       i_Reset;
   logic       i_write_en;
   logic [4:0] i_write_addr;
   logic [7:0] i_write_data;
   logic       i_read_en;
   logic [4:0] i_read_addr;
   logic [7:0] o_read_data;
   logic       o_read_valid;
   logic       i_Frame_Start;
   logic       i_Commit_Hold;
   logic [4:0] i_Pixel_Index;
   logic [7:0] o_Pixel_Color;
   logic       o_Dirty;
   logic       o_Commit;

   int tests_run = 0;
   int tests_failed = 0;
   logic [7:0] rd_exp_q [$];

   color_palette_regs dut (
      .i_Clk        (i_Clk),
      .i_Reset      (i_Reset),
      .i_write_en   (i_write_en),
      .i_write_addr (i_write_addr),
      .i_write_data (i_write_data),
      .i_read_en    (i_read_en),
      .i_read_addr  (i_read_addr),
      .o_read_data  (o_read_data),
      .o_read_valid (o_read_valid),
      .i_Frame_Start(i_Frame_Start),
      .i_Commit_Hold(i_Commit_Hold),
      .i_Pixel_Index(i_Pixel_Index),
      .o_Pixel_Color(o_Pixel_Color),
      .o_Dirty      (o_Dirty),
      .o_Commit     (o_Commit)
   );

   always #5 i_Clk = ~i_Clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the active edge; outputs are read there or at negedge.
   task automatic tick();
      @(posedge i_Clk);
      #1;
   endtask

   task automatic do_write(input logic [4:0] addr, input logic [7:0] data);
      i_write_en   = 1'b1;
      i_write_addr = addr;
      i_write_data = data;
      tick();
      i_write_en   = 1'b0;
   endtask

   task automatic do_read(input logic [4:0] addr, input logic [7:0] exp);
      i_read_en   = 1'b1;
      i_read_addr = addr;
      rd_exp_q.push_back(exp);
      tick();
      i_read_en   = 1'b0;
      check("rd_valid_latency", o_read_valid, 1);
   endtask

   task automatic frame_start(input logic hold);
      i_Frame_Start = 1'b1;
      i_Commit_Hold = hold;
      tick();
      i_Frame_Start = 1'b0;
      i_Commit_Hold = 1'b0;
   endtask

   // Read scoreboard: every valid pulse must match the oldest outstanding expectation.
   always @(negedge i_Clk) begin
      if (o_read_valid === 1'b1) begin
         if (rd_exp_q.size() == 0) check("rd_spurious_valid", 1, 0);
         else check("rd_data", o_read_data, rd_exp_q.pop_front());
      end
   end

   initial begin
      i_Reset = 1'b1; i_write_en = 1'b0; i_write_addr = '0; i_write_data = '0;
      i_read_en = 1'b0; i_read_addr = '0; i_Frame_Start = 1'b0; i_Commit_Hold = 1'b0;
      i_Pixel_Index = '0;

      // 1 Reset
      tick(); tick();
      check("rst_dirty", o_Dirty, 0);
      check("rst_commit", o_Commit, 0);
      check("rst_pixel", o_Pixel_Color, 8'h00);
      check("rst_rd_valid", o_read_valid, 0);
      check("rst_rd_data", o_read_data, 8'h00);
      i_Reset = 1'b0;
      do_read(5'd0, 8'h00);
      do_read(5'd17, 8'h00);
      do_read(5'd31, 8'h00);

      // 2 Write then read, then same-cycle read/write returns old data
      do_write(5'd3, 8'hA5);
      do_read(5'd3, 8'hA5);
      i_write_en = 1'b1; i_write_addr = 5'd3; i_write_data = 8'h5A;
      i_read_en = 1'b1; i_read_addr = 5'd3; rd_exp_q.push_back(8'hA5);
      tick();
      i_write_en = 1'b0; i_read_en = 1'b0;
      tick();
      check("rd_hold_data", o_read_data, 8'hA5);
      check("rd_valid_low", o_read_valid, 0);
      do_read(5'd3, 8'h5A);
      frame_start(1'b0);
      check("commit_pre3", o_Commit, 1);
      tick();

      // 3 Tear-free update of entry 7
      i_Pixel_Index = 5'd7;
      do_write(5'd7, 8'h1C);
      tick(); tick();
      check("tear_dirty", o_Dirty, 1);
      check("tear_pixel_old", o_Pixel_Color, 8'h00);
      frame_start(1'b0);
      check("tear_commit", o_Commit, 1);
      check("tear_dirty_clr", o_Dirty, 0);
      check("tear_pixel_commit_cycle", o_Pixel_Color, 8'h00);
      tick();
      check("tear_commit_pulse", o_Commit, 0);
      check("tear_pixel_new", o_Pixel_Color, 8'h1C);
      frame_start(1'b0);
      check("clean_fs_no_commit", o_Commit, 0);

      // 4 Commit hold
      i_Pixel_Index = 5'd0;
      do_write(5'd0, 8'hFF);
      frame_start(1'b1);
      check("hold_no_commit", o_Commit, 0);
      check("hold_dirty", o_Dirty, 1);
      tick(); tick();
      check("hold_pixel_old", o_Pixel_Color, 8'h00);
      frame_start(1'b0);
      check("hold_release_commit", o_Commit, 1);
      tick();
      check("hold_pixel_new", o_Pixel_Color, 8'hFF);

      // 5 Write collides with committing frame start
      i_Pixel_Index = 5'd9;
      do_write(5'd1, 8'h44);
      i_write_en = 1'b1; i_write_addr = 5'd9; i_write_data = 8'h22;
      frame_start(1'b0);
      i_write_en = 1'b0;
      check("coll_commit", o_Commit, 1);
      check("coll_dirty", o_Dirty, 1);
      tick(); tick();
      check("coll_pixel_old", o_Pixel_Color, 8'h00);
      i_Pixel_Index = 5'd1;
      tick(); tick();
      check("coll_pixel_other", o_Pixel_Color, 8'h44);
      i_Pixel_Index = 5'd9;
      frame_start(1'b0);
      check("coll_commit2", o_Commit, 1);
      tick();
      check("coll_pixel_new", o_Pixel_Color, 8'h22);
      check("coll_dirty_clr", o_Dirty, 0);

      // 6 Reset while a commit is pending
      do_write(5'd4, 8'h33);
      check("rstp_dirty", o_Dirty, 1);
      i_Reset = 1'b1; i_Frame_Start = 1'b1;
      tick();
      i_Reset = 1'b0; i_Frame_Start = 1'b0;
      check("rstp_commit", o_Commit, 0);
      check("rstp_dirty_clr", o_Dirty, 0);
      check("rstp_pixel", o_Pixel_Color, 8'h00);
      tick();
      check("rstp_commit_after", o_Commit, 0);
      do_read(5'd4, 8'h00);
      do_read(5'd9, 8'h00);
      tick(); tick();
      check("rd_queue_drained", rd_exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
